// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: pin synchroniser, KCLK deglitch filter, 11-bit frame FSM with
// parity/stop/timeout checks, E0/F0 prefix folding and a show-ahead code FIFO.
// "release" is a reserved word, so the break-flag output is named key_release.
module ps2_scan_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       KCLK,
  input  logic       KDATA,
  input  logic       rd_en,
  output logic       valid,
  output logic [7:0] code,
  output logic       extended,
  output logic       key_release,
  output logic       frame_err,
  output logic       overflow
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Pin synchronisers; reset to the idle-high level so no false edge follows reset
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] kclk_sync_q;
  logic [SYNC_STAGES-1:0] kdata_sync_q;
  logic                   kclk_s;
  logic                   kdata_s;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      kclk_sync_q  <= '1;
      kdata_sync_q <= '1;
    end else begin
      kclk_sync_q  <= {kclk_sync_q[SYNC_STAGES-2:0], KCLK};
      kdata_sync_q <= {kdata_sync_q[SYNC_STAGES-2:0], KDATA};
    end
  end

  assign kclk_s  = kclk_sync_q[SYNC_STAGES-1];
  assign kdata_s = kdata_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // KCLK deglitch: flip only after FILTER_LEN consecutive differing samples
  // ---------------------------------------------------------------------------
  logic           kclk_filt_q;
  logic [FCW-1:0] filt_cnt_q;
  logic           filt_flip;
  logic           fe;

  assign filt_flip = (kclk_s != kclk_filt_q) && (filt_cnt_q == FCW'(FILTER_LEN - 1));
  assign fe        = filt_flip && kclk_filt_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      kclk_filt_q <= 1'b1;
      filt_cnt_q  <= '0;
    end else if (kclk_s == kclk_filt_q) begin
      filt_cnt_q <= '0;
    end else if (filt_flip) begin
      kclk_filt_q <= ~kclk_filt_q;
      filt_cnt_q  <= '0;
    end else begin
      filt_cnt_q <= filt_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM with timeout and prefix folding
  // ---------------------------------------------------------------------------
  state_t         state_q;
  logic [2:0]     bit_cnt_q;
  logic [7:0]     shift_q;
  logic           parity_q;
  logic [TCW-1:0] tmo_cnt_q;
  logic           ext_q;
  logic           brk_q;
  logic           frame_err_q;
  logic           push_q;
  entry_t         push_entry_q;
  logic           frame_good;

  assign frame_good = kdata_s && (^{shift_q, parity_q});

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      tmo_cnt_q    <= '0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      frame_err_q  <= 1'b0;
      push_q       <= 1'b0;
      push_entry_q <= '0;
    end else begin
      frame_err_q <= 1'b0;
      push_q      <= 1'b0;

      if (fe || state_q == S_IDLE) tmo_cnt_q <= '0;
      else                         tmo_cnt_q <= tmo_cnt_q + 1'b1;

      if (fe) begin
        unique case (state_q)
          S_IDLE: begin
            if (!kdata_s) begin
              state_q   <= S_DATA;
              bit_cnt_q <= '0;
            end
          end
          S_DATA: begin
            shift_q   <= {kdata_s, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
          end
          S_PARITY: begin
            parity_q <= kdata_s;
            state_q  <= S_STOP;
          end
          S_STOP: begin
            state_q <= S_IDLE;
            if (!frame_good) begin
              frame_err_q <= 1'b1;
              ext_q       <= 1'b0;
              brk_q       <= 1'b0;
            end else if (shift_q == 8'hE0) begin
              ext_q <= 1'b1;
            end else if (shift_q == 8'hF0) begin
              brk_q <= 1'b1;
            end else begin
              push_q       <= 1'b1;
              push_entry_q <= '{ext: ext_q, brk: brk_q, code: shift_q};
              ext_q        <= 1'b0;
              brk_q        <= 1'b0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (state_q != S_IDLE && tmo_cnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
        // Device stalled mid-frame: abandon it and any pending prefix
        state_q     <= S_IDLE;
        frame_err_q <= 1'b1;
        ext_q       <= 1'b0;
        brk_q       <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Show-ahead code FIFO
  // ---------------------------------------------------------------------------
  entry_t        mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          overflow_q;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_ok;
  entry_t        head;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign pop     = rd_en && !empty;
  assign push_ok = push_q && (!full || pop);

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage is deliberately not reset; count/pointers define validity and
  // the outputs are gated with valid, so stale contents are never visible.
  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_entry_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push_ok) wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (push_q && !push_ok) overflow_q <= 1'b1;
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign valid       = !empty;
  assign code        = valid ? head.code : 8'h00;
  assign extended    = valid && head.ext;
  assign key_release = valid && head.brk;
  assign frame_err   = frame_err_q;
  assign overflow    = overflow_q;

endmodule
